// File: rtl/fp_acc_seq.sv
// fp_acc_seq: streaming floating-point reduction sequencer.
// Accepts one float per cycle and pairs operands onto an external pipelined
// adder. Adder results come back as operands, and one sum is emitted per
// vector. A single holding register H parks an unpaired operand.
// Optional feature macro: FP_ACC_TERM_COUNT_EN adds the out_count port, which
// reports the per-vector count of accepted elements.
module fp_acc_seq #(
  parameter int EXP     = 8,
  parameter int MANT    = 23,
  parameter int WIDTH   = EXP + MANT + 1,
  parameter int ADD_LAT = 3
`ifdef FP_ACC_TERM_COUNT_EN
  ,
  parameter int COUNT_W = 16
`endif
) (
  input  logic             clock,
  input  logic             clock_areset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             add_valid,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic             add_result_valid,
  input  logic [WIDTH-1:0] add_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err
`ifdef FP_ACC_TERM_COUNT_EN
  ,
  output logic [COUNT_W-1:0] out_count
`endif
);

  localparam int F_W = $clog2(ADD_LAT + 2);

  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] h_val;
  logic [WIDTH-1:0] h_val_nxt;
  logic             h_vld;
  logic             h_vld_nxt;
  logic [F_W-1:0]   f_cnt;
  logic [F_W-1:0]   f_cnt_nxt;
  logic             iss;
  logic [WIDTH-1:0] iss_a;
  logic [WIDTH-1:0] iss_b;
  logic             acc_in;
  logic             acc_r;
  logic             drop_r;
  logic             out_hs;

`ifdef FP_ACC_TERM_COUNT_EN
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction
`endif

  assign acc_in = in_valid & in_ready;
  assign acc_r  = add_result_valid & (f_cnt != '0);
  assign drop_r = add_result_valid & (f_cnt == '0);
  assign out_hs = (state == DONE) & out_ready;

  // Pairing decision, in-flight accounting and FSM next state
  always_comb begin
    state_nxt = state;
    h_val_nxt = h_val;
    h_vld_nxt = h_vld;
    iss       = 1'b0;
    iss_a     = h_val;
    iss_b     = add_result;
    f_cnt_nxt = f_cnt;

    if (acc_r && acc_in) begin
      iss   = 1'b1;
      iss_a = add_result;
      iss_b = in_data;
    end else if (acc_r) begin
      if (h_vld) begin
        iss       = 1'b1;
        iss_a     = h_val;
        iss_b     = add_result;
        h_vld_nxt = 1'b0;
      end else begin
        h_val_nxt = add_result;
        h_vld_nxt = 1'b1;
      end
    end else if (acc_in) begin
      if (h_vld) begin
        iss       = 1'b1;
        iss_a     = h_val;
        iss_b     = in_data;
        h_vld_nxt = 1'b0;
      end else begin
        h_val_nxt = in_data;
        h_vld_nxt = 1'b1;
      end
    end

    // An issue and a returned result in the same cycle cancel out
    if (iss && !acc_r) begin
      f_cnt_nxt = f_cnt + F_W'(1);
    end else if (!iss && acc_r) begin
      f_cnt_nxt = f_cnt - F_W'(1);
    end

    case (state)
      ACCUM: if (acc_in && in_last) state_nxt = DRAIN;
      DRAIN: if (f_cnt == '0 && h_vld) state_nxt = DONE;
      DONE: begin
        if (out_ready) begin
          state_nxt = ACCUM;
          h_vld_nxt = 1'b0;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Control registers: FSM, registered ready, holding flag, in-flight count, sticky error
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      state     <= ACCUM;
      in_ready  <= 1'b0;
      h_vld     <= 1'b0;
      f_cnt     <= '0;
      err       <= 1'b0;
      add_valid <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == ACCUM);
      h_vld     <= h_vld_nxt;
      f_cnt     <= f_cnt_nxt;
      err       <= err | drop_r;
      add_valid <= iss;
      out_valid <= (state_nxt == DONE);
    end
  end

  // Data registers: holding value, adder operands, emitted sum
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      h_val    <= '0;
      add_a    <= '0;
      add_b    <= '0;
      out_data <= '0;
    end else begin
      h_val <= h_val_nxt;
      if (iss) begin
        add_a <= iss_a;
        add_b <= iss_b;
      end
      if (state == DRAIN && state_nxt == DONE) begin
        out_data <= h_val;
      end
    end
  end

`ifdef FP_ACC_TERM_COUNT_EN
  // Per-vector element count, held through DONE and cleared on the output handshake
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      out_count <= '0;
    end else if (out_hs) begin
      out_count <= '0;
    end else if (acc_in) begin
      out_count <= sat_inc(out_count);
    end
  end
`else
  logic unused_hs;
  assign unused_hs = out_hs;
`endif

endmodule

// File: tb/tb_fp_acc_seq.sv
// Testbench for fp_acc_seq with an integer-valued behavioural float adder.
module tb_fp_acc_seq;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        add_valid;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_result_valid = 1'b0;
  logic [31:0] add_result = 32'h0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        err;
`ifdef FP_ACC_TERM_COUNT_EN
  logic [15:0] out_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int lat = 3;
  bit inj = 1'b0;
  int peak = 0;
  int av_count = 0;
  logic        pv [0:7];
  logic [31:0] pd [0:7];
  logic [31:0] vbits [0:63];

  fp_acc_seq #(.ADD_LAT(3)) dut (
    .clock            (clock),
    .clock_areset_n   (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_last          (in_last),
    .add_valid        (add_valid),
    .add_a            (add_a),
    .add_b            (add_b),
    .add_result_valid (add_result_valid),
    .add_result       (add_result),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .err              (err)
`ifdef FP_ACC_TERM_COUNT_EN
    ,
    .out_count        (out_count)
`endif
  );

  always #5 clock = ~clock;

  // Small non-negative integer to single-precision bits (exact below 2^24)
  function automatic logic [31:0] enc(input int unsigned v);
    int p;
    logic [31:0] sh;
    if (v == 0) return 32'h0;
    p = 0;
    for (int k = 0; k < 32; k++) if (v[k]) p = k;
    sh = v << (23 - p);
    return {1'b0, 8'(p + 127), sh[22:0]};
  endfunction

  function automatic int unsigned dec(input logic [31:0] b);
    int e;
    logic [23:0] m;
    if (b[30:0] == 31'h0) return 0;
    e = int'(b[30:23]) - 127;
    if (e < 0 || e > 23) return 0;
    m = {1'b1, b[22:0]};
    return 32'(m >> (23 - e));
  endfunction

  // Behavioural adder: fixed latency 'lat', plus an injectable stray result pulse
  always @(negedge clock) begin
    int live;
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        pv[k] = 1'b0;
        pd[k] = 32'h0;
      end
      add_result_valid = 1'b0;
      add_result = 32'h0;
    end else begin
      for (int k = 7; k > 0; k--) begin
        pv[k] = (k <= lat) ? pv[k-1] : 1'b0;
        pd[k] = pd[k-1];
      end
      pv[0] = add_valid;
      pd[0] = enc(dec(add_a) + dec(add_b));
      if (add_valid) av_count++;
      live = 0;
      for (int k = 0; k <= lat; k++) if (pv[k]) live++;
      if (live > peak) peak = live;
      add_result_valid = pv[lat] | inj;
      add_result = pd[lat];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic run_vector(input int n, input bit gaps, input bit first_now,
                            input logic [31:0] want_sum, input logic want_err,
                            input string tag);
    int i;
    int guard;
    bit skip_wait;
    i = 0;
    guard = 0;
    skip_wait = first_now;
    while (i < n && guard < 2000) begin
      if (skip_wait) skip_wait = 1'b0;
      else @(negedge clock);
      guard++;
      if ((gaps && $urandom_range(0, 2) == 0) || !in_ready) begin
        in_valid = 1'b0;
        in_last = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data = vbits[i];
        in_last = (i == n - 1);
        i++;
      end
    end
    check({tag, "_accepted"}, i, n);
    @(negedge clock);
    in_valid = 1'b0;
    in_last = 1'b0;
    guard = 0;
    while (!out_valid && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_sum"}, out_data, want_sum);
`ifdef FP_ACC_TERM_COUNT_EN
    check({tag, "_count"}, out_count, n);
`endif
    check({tag, "_err"}, err, want_err);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check({tag, "_ready_after"}, in_ready, 1);
    check({tag, "_valid_after"}, out_valid, 0);
  endtask

  initial begin
    int av0;
    int n;
    int unsigned sum;
    int unsigned val;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 32'h0;
    in_last = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_ctrl", {in_ready, out_valid, add_valid, err}, 0);
    check("rst_add", {add_a, add_b}, 0);
    check("rst_out", out_data, 0);
`ifdef FP_ACC_TERM_COUNT_EN
    check("rst_count", out_count, 0);
`endif
    @(negedge clock);
    rst_n = 1'b1;
    #1 check("rel_ready_low", in_ready, 0);
    @(negedge clock);
    check("rel_ready", in_ready, 1);

    // Single element, then 5 cycles of downstream backpressure
    av0 = av_count;
    in_valid = 1'b1;
    in_data = 32'h3F800000;
    in_last = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    in_last = 1'b0;
    check("single_t1", out_valid, 0);
    @(negedge clock);
    check("single_t2", out_valid, 1);
    check("single_data", out_data, 32'h3F800000);
`ifdef FP_ACC_TERM_COUNT_EN
    check("single_count", out_count, 1);
`endif
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, 32'h3F800000);
      check("hold_ready", in_ready, 0);
    end
    check("single_no_add", av_count - av0, 0);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("next_ready", in_ready, 1);
    check("next_valid", out_valid, 0);

    // 1+2+3+4 back to back, first element right after the handshake
    vbits[0] = enc(1);
    vbits[1] = enc(2);
    vbits[2] = enc(3);
    vbits[3] = enc(4);
    lat = 3;
    run_vector(4, 1'b0, 1'b1, 32'h41200000, 1'b0, "sum4");
    check("peak4", peak <= 4, 1);

    // Sixteen ones with gaps at two adder latencies
    for (int k = 0; k < 16; k++) vbits[k] = 32'h3F800000;
    lat = 1;
    run_vector(16, 1'b1, 1'b0, 32'h41800000, 1'b0, "ones_l1");
    lat = 3;
    run_vector(16, 1'b1, 1'b0, 32'h41800000, 1'b0, "ones_l3");

    // Stray adder result while idle
    @(posedge clock);
    #1 inj = 1'b1;
    @(posedge clock);
    #1 inj = 1'b0;
    @(negedge clock);
    check("err_set", err, 1);
    repeat (3) @(negedge clock);
    check("err_sticky", err, 1);
    vbits[0] = enc(7);
    vbits[1] = enc(8);
    vbits[2] = enc(9);
    run_vector(3, 1'b1, 1'b0, enc(24), 1'b1, "after_err");

    // Reset in the middle of a vector
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data = enc(5);
      in_last = 1'b0;
    end
    @(negedge clock);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {in_ready, out_valid, add_valid, err}, 0);
    check("midrst_add", {add_a, add_b}, 0);
    check("midrst_out", out_data, 0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    check("midrst_ready", in_ready, 1);
    vbits[0] = enc(2);
    vbits[1] = enc(2);
    run_vector(2, 1'b0, 1'b0, 32'h40800000, 1'b0, "post_rst");

    // Random vectors against an integer sum
    for (int v = 0; v < 6; v++) begin
      n = $urandom_range(1, 20);
      sum = 0;
      for (int k = 0; k < n; k++) begin
        val = $urandom_range(1, 1000);
        vbits[k] = enc(val);
        sum += val;
      end
      lat = $urandom_range(1, 3);
      run_vector(n, 1'($urandom_range(0, 1)), 1'b0, enc(sum), 1'b0, "rand");
    end
    check("peak_all", peak <= 4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
